// File: rtl/vga_draw_sched.sv
// vga_draw_sched: runs selected VGA drawing engines one at a time onto a single framebuffer write port.
// Optional framebuffer clear pass before the engines: define VGA_SCHED_CLEAR_EN.
module vga_draw_sched #(
  parameter int          N_ENG    = 2,
  parameter int          XMAX     = 159,
  parameter int          YMAX     = 119,
  parameter logic [11:0] BG_COLOR = 12'h000,
  parameter int          TIMEOUT  = 20000
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [N_ENG-1:0]    eng_mask_i,
  input  logic [N_ENG-1:0]    eng_finished_i,
  input  logic [8*N_ENG-1:0]  eng_x_i,
  input  logic [8*N_ENG-1:0]  eng_y_i,
  input  logic [12*N_ENG-1:0] eng_color_i,
  output logic [N_ENG-1:0]    eng_rst_o,
  output logic [N_ENG-1:0]    eng_enable_o,
  output logic                fb_we_o,
  output logic [7:0]          fb_x_o,
  output logic [7:0]          fb_y_o,
  output logic [11:0]         fb_color_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [1:0]          cur_eng_o
);
  typedef enum logic [2:0] {
    IDLE,
`ifdef VGA_SCHED_CLEAR_EN
    CLEAR,
`endif
    SELECT,
    ARM,
    RUN,
    DONE
  } state_e;
  state_e             state_q, state_d;
  logic [N_ENG-1:0]   mask_q, mask_d;
  logic [1:0]         cur_q, cur_d;
  logic [15:0]        wd_q, wd_d;
  logic               err_q, err_d;
  logic               fb_we_q, fb_we_d;
  logic [7:0]         fb_x_q, fb_x_d, fb_y_q, fb_y_d;
  logic [11:0]        fb_color_q, fb_color_d;
  logic [N_ENG-1:0]   sel_oh;
  logic [1:0]         low;
  logic               fin;
  logic               timeout;
  logic [7:0]         px, py;
  logic [11:0]        pc;
`ifdef VGA_SCHED_CLEAR_EN
  logic [7:0]         clr_x_q, clr_x_d, clr_y_q, clr_y_d;
  logic               clr_xend, clr_last;
  assign clr_xend = clr_x_q == 8'(XMAX);
  assign clr_last = clr_xend && clr_y_q == 8'(YMAX);
  // Raster scan of the clear pass: x inner, y outer, rewinding to origin after the last pixel
  always_comb begin
    clr_x_d = state_q == CLEAR ? (clr_xend ? '0 : clr_x_q + 8'd1) : clr_x_q;
    clr_y_d = state_q == CLEAR && clr_xend ? (clr_last ? '0 : clr_y_q + 8'd1) : clr_y_q;
  end
`endif
  assign timeout = wd_q == 16'(TIMEOUT - 1);
  // Decode selected engine, lowest pending engine, and mux the selected engine's pixel bus
  always_comb begin
    sel_oh = '0;
    low    = '0;
    px     = '0;
    py     = '0;
    pc     = '0;
    for (int k = 0; k < N_ENG; k++) sel_oh[k] = cur_q == 2'(k);
    for (int k = N_ENG - 1; k >= 0; k--) if (mask_q[k]) low = 2'(k);
    for (int k = 0; k < N_ENG; k++) begin
      if (sel_oh[k]) begin
        px = eng_x_i[8*k +: 8];
        py = eng_y_i[8*k +: 8];
        pc = eng_color_i[12*k +: 12];
      end
    end
    fin = |(eng_finished_i & sel_oh);
  end
  // Sequencer next state: select, arm and run each pending engine, watchdog on RUN
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cur_d   = cur_q;
    wd_d    = wd_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          mask_d = eng_mask_i;
          err_d  = 1'b0;
`ifdef VGA_SCHED_CLEAR_EN
          state_d = CLEAR;
`else
          state_d = SELECT;
`endif
        end
      end
`ifdef VGA_SCHED_CLEAR_EN
      CLEAR: state_d = clr_last ? SELECT : CLEAR;
`endif
      SELECT: begin
        if (mask_q == '0) state_d = DONE;
        else begin
          cur_d   = low;
          wd_d    = '0;
          state_d = ARM;
        end
      end
      ARM: state_d = RUN;
      RUN: begin
        wd_d = wd_q + 16'd1;
        if (fin || timeout) begin
          mask_d  = mask_q & ~sel_oh;
          err_d   = err_q | !fin;
          state_d = SELECT;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Framebuffer write port: engine pixels while running, background during the clear pass
  always_comb begin
    fb_we_d    = state_q == RUN && !fin;
    fb_x_d     = fb_we_d ? px : fb_x_q;
    fb_y_d     = fb_we_d ? py : fb_y_q;
    fb_color_d = fb_we_d ? pc : fb_color_q;
`ifdef VGA_SCHED_CLEAR_EN
    if (state_q == CLEAR) begin
      fb_we_d    = 1'b1;
      fb_x_d     = clr_x_q;
      fb_y_d     = clr_y_q;
      fb_color_d = BG_COLOR;
    end
`endif
  end
  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      cur_q      <= '0;
      wd_q       <= '0;
      err_q      <= 1'b0;
      fb_we_q    <= 1'b0;
      fb_x_q     <= '0;
      fb_y_q     <= '0;
      fb_color_q <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      cur_q      <= cur_d;
      wd_q       <= wd_d;
      err_q      <= err_d;
      fb_we_q    <= fb_we_d;
      fb_x_q     <= fb_x_d;
      fb_y_q     <= fb_y_d;
      fb_color_q <= fb_color_d;
    end
  end
`ifdef VGA_SCHED_CLEAR_EN
  // Clear-pass scan counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clr_x_q <= '0;
      clr_y_q <= '0;
    end else begin
      clr_x_q <= clr_x_d;
      clr_y_q <= clr_y_d;
    end
  end
`endif
  assign eng_rst_o    = state_q == ARM ? sel_oh : '0;
  assign eng_enable_o = state_q == RUN ? sel_oh : '0;
  assign busy_o       = state_q != IDLE;
  assign done_o       = state_q == DONE;
  assign err_o        = err_q;
  assign cur_eng_o    = cur_q;
  assign fb_we_o      = fb_we_q;
  assign fb_x_o       = fb_x_q;
  assign fb_y_o       = fb_y_q;
  assign fb_color_o   = fb_color_q;
endmodule

// File: tb/tb_vga_draw_sched.sv
// tb_vga_draw_sched: self-checking bench for vga_draw_sched with behavioural engine models and a frame-level reference.
module tb_vga_draw_sched;
  localparam int TO = 16;
  localparam int XM = 3;
  localparam int YM = 1;
  localparam logic [11:0] BG = 12'hABC;
`ifdef VGA_SCHED_CLEAR_EN
  localparam int CLR = (XM + 1) * (YM + 1);
`else
  localparam int CLR = 0;
`endif
  typedef struct {
    logic [1:0] mask;
    int n0;
    int n1;
    int writes;
    logic err;
  } vec_t;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic start = 1'b0;
  logic [1:0] eng_mask = '0;
  logic [1:0] eng_finished;
  logic [15:0] eng_x, eng_y;
  logic [23:0] eng_color;
  logic [1:0] eng_rst, eng_enable;
  logic fb_we, busy, done, err;
  logic [7:0] fb_x, fb_y;
  logic [11:0] fb_color;
  logic [1:0] cur_eng;
  int checks = 0;
  int fails = 0;
  int fin_n [2] = '{0, 0};
  logic [11:0] seed = '0;
  logic [15:0] ecnt [2] = '{16'd0, 16'd0};
  vec_t tbl [8];

  always #5 clk = ~clk;

  vga_draw_sched #(.N_ENG(2), .XMAX(XM), .YMAX(YM), .BG_COLOR(BG), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start), .eng_mask_i(eng_mask),
    .eng_finished_i(eng_finished), .eng_x_i(eng_x), .eng_y_i(eng_y), .eng_color_i(eng_color),
    .eng_rst_o(eng_rst), .eng_enable_o(eng_enable), .fb_we_o(fb_we), .fb_x_o(fb_x),
    .fb_y_o(fb_y), .fb_color_o(fb_color), .busy_o(busy), .done_o(done), .err_o(err),
    .cur_eng_o(cur_eng)
  );

  function automatic logic [27:0] pix(input int k, input int j, input logic [11:0] s);
    return {8'(j * 3 + k * 50), 8'(j ^ (k * 7)), 12'(j * 37 + k * 1000) ^ s};
  endfunction

  always @(posedge clk)
    for (int k = 0; k < 2; k++)
      if (eng_rst[k]) ecnt[k] <= '0;
      else if (eng_enable[k]) ecnt[k] <= ecnt[k] + 16'd1;

  always_comb begin
    eng_finished = '0;
    eng_x = '0;
    eng_y = '0;
    eng_color = '0;
    for (int k = 0; k < 2; k++) begin
      eng_finished[k] = fin_n[k] != 0 && int'(ecnt[k]) >= fin_n[k] - 1;
      {eng_x[8*k +: 8], eng_y[8*k +: 8], eng_color[12*k +: 12]} = pix(k, int'(ecnt[k]), seed);
    end
  end

  function automatic longint all_out();
    return longint'({eng_rst, eng_enable, fb_we, fb_x, fb_y, fb_color, busy, done, err, cur_eng});
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (!done && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk(name, done, 1);
  endtask

  task automatic run_seq(input logic [1:0] m, input int n0, input int n1, output int nw, output logic e);
    logic [27:0] exp_q[$];
    logic [27:0] got_q[$];
    int ren [2];
    int wr [2];
    int rst_cnt [2];
    int en_cnt [2];
    int rst_at [2];
    int exp_at [2];
    int cyc, exp_cyc, bad_oh, first_bad, n;
    logic exp_err, b1, lng;
    fin_n[0] = n0;
    fin_n[1] = n1;
    seed = 12'($urandom);
    exp_err = 1'b0;
    exp_cyc = CLR + 2;
`ifdef VGA_SCHED_CLEAR_EN
    for (int y = 0; y <= YM; y++)
      for (int x = 0; x <= XM; x++) exp_q.push_back({8'(x), 8'(y), BG});
`endif
    for (int k = 0; k < 2; k++) begin
      n = k == 0 ? n0 : n1;
      lng = n == 0 || n > TO;
      ren[k] = m[k] ? (lng ? TO : n) : 0;
      wr[k] = m[k] ? (lng ? TO : n - 1) : 0;
      if (m[k] && lng) exp_err = 1'b1;
      exp_at[k] = CLR + (k == 1 ? wr[0] : 0);
      exp_cyc += m[k] ? 2 + ren[k] : 0;
      for (int j = 0; j < wr[k]; j++) exp_q.push_back(pix(k, j, seed));
      rst_cnt[k] = 0;
      en_cnt[k] = 0;
      rst_at[k] = -1;
    end
    eng_mask = m;
    start = 1'b1;
    cyc = 0;
    bad_oh = 0;
    b1 = 1'b0;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) b1 = busy;
      start = 1'b0;
      if (fb_we) got_q.push_back({fb_x, fb_y, fb_color});
      for (int k = 0; k < 2; k++) begin
        if (eng_rst[k]) begin
          rst_cnt[k]++;
          rst_at[k] = got_q.size();
        end
        if (eng_enable[k]) en_cnt[k]++;
      end
      if (eng_enable == 2'b11) bad_oh++;
      if (done) break;
    end
    chk("busy_after_start", b1, 1);
    chk("done_cycle", cyc, exp_cyc);
    chk("err_flag", err, exp_err);
    chk("write_count", got_q.size(), exp_q.size());
    first_bad = -1;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] != exp_q[i] && first_bad < 0) first_bad = i;
    chk("write_data_first_bad_index", first_bad, -1);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_pulses_eng%0d", k), rst_cnt[k], m[k]);
      chk($sformatf("run_cycles_eng%0d", k), en_cnt[k], ren[k]);
      if (m[k]) chk($sformatf("writes_before_rst_eng%0d", k), rst_at[k], exp_at[k]);
    end
    chk("enable_onehot_violations", bad_oh, 0);
    @(negedge clk);
    chk("done_then_idle", {done, busy}, 0);
    nw = got_q.size() - CLR;
    e = err;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int nw, t, dn, bz;
    logic e;
    tbl[0] = '{2'b11, 6, 4, 8, 1'b0};
    tbl[1] = '{2'b10, 6, 4, 3, 1'b0};
    tbl[2] = '{2'b00, 5, 5, 0, 1'b0};
    tbl[3] = '{2'b01, 1, 1, 0, 1'b0};
    tbl[4] = '{2'b11, 0, 2, 17, 1'b1};
    tbl[5] = '{2'b11, 16, 17, 31, 1'b1};
    tbl[6] = '{2'b01, 17, 0, 16, 1'b1};
    tbl[7] = '{2'b10, 0, 16, 15, 1'b0};
    #3;
    chk("reset_outputs_async", all_out(), 0);
    repeat (2) @(negedge clk);
    chk("reset_outputs_held", all_out(), 0);
    rst_ni = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      run_seq(tbl[i].mask, tbl[i].n0, tbl[i].n1, nw, e);
      chk($sformatf("tbl%0d_writes", i), nw, tbl[i].writes);
      chk($sformatf("tbl%0d_err", i), e, tbl[i].err);
      if (tbl[i].mask == 2'b10) chk($sformatf("tbl%0d_cur_eng", i), cur_eng, 1);
    end
    run_seq(2'b11, 0, 3, nw, e);
    chk("timeout_sets_err", e, 1);
    fin_n[0] = 2;
    eng_mask = 2'b01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_clears_err", err, 0);
    wait_done("after_err_clear_done");
    @(negedge clk);
    fin_n[0] = 3;
    eng_mask = 2'b01;
    start = 1'b1;
    @(negedge clk);
    wait_done("hold_first_done");
    start = 1'b0;
    dn = 0;
    bz = 0;
    repeat (12) begin
      @(negedge clk);
      dn += int'(done);
      bz += int'(busy);
    end
    chk("hold_no_second_done", dn, 0);
    chk("hold_no_second_busy", bz, 0);
    start = 1'b1;
    @(negedge clk);
    wait_done("rehold_first_done");
    @(negedge clk);
    chk("rehold_idle_after_done", busy, 0);
    @(negedge clk);
    chk("rehold_restart", busy, 1);
    start = 1'b0;
    wait_done("rehold_second_done");
    @(negedge clk);
    fin_n[0] = 0;
    fin_n[1] = 0;
    eng_mask = 2'b11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!eng_enable[1] && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("eng1_running_before_reset", eng_enable[1], 1);
    chk("err_before_reset", err, 1);
    repeat (3) @(negedge clk);
    #2 rst_ni = 1'b0;
    #1 chk("midrun_reset_async", all_out(), 0);
    @(negedge clk);
    chk("midrun_reset_held", all_out(), 0);
    rst_ni = 1'b1;
    @(negedge clk);
    run_seq(2'b01, 3, 0, nw, e);
    chk("post_reset_writes", nw, 2);
    chk("post_reset_err", e, 0);
    for (int i = 0; i < 25; i++) begin
      run_seq(2'($urandom_range(0, 3)), int'($urandom_range(0, 20)), int'($urandom_range(0, 20)), nw, e);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/vga_draw_sched.md
# vga_draw_sched

Frame-level scheduler for the VGA drawing engines such as `vga_sin`. Each engine has an enable/reset/finished handshake and emits `CounterX`, `CounterY` and `color`. On a `start` pulse the block runs the selected engines one at a time in ascending index order. It re-arms each engine with a reset pulse, owns the single framebuffer write port and muxes the active engine's pixels onto it. A watchdog aborts an engine that never raises `finished`.

## Interface
- `N_ENG`, 2, number of engine slots (1..4).
- `XMAX`, 159, last X coordinate of the framebuffer (8-bit).
- `YMAX`, 119, last Y coordinate of the framebuffer (8-bit).
- `BG_COLOR`, 12'h000, clear-pass colour.
- `TIMEOUT`, 20000, maximum RUN cycles per engine (16-bit, ≥1).

- `clk` in 1: single clock; all state is updated on its rising edge.
- `reset` in 1: asynchronous, active-low; asserting low clears all state immediately.
- `start` in 1: request a frame sequence; sampled only in IDLE.
- `eng_mask` in N_ENG: engines to run; captured into `mask_q` when `start` is accepted.
- `eng_finished` in N_ENG: per-engine finished flag.
- `eng_x` in 8*N_ENG: packed X coordinate bus; engine k at [8k+7:8k].
- `eng_y` in 8*N_ENG: packed Y coordinate bus; engine k at [8k+7:8k].
- `eng_color` in 12*N_ENG: packed colour bus; engine k at [12k+11:12k].
- `eng_rst` out N_ENG: active-high re-arm pulse to engine k.
- `eng_enable` out N_ENG: enable to engine k; at most one bit high at any time.
- `fb_we` out 1: framebuffer write enable.
- `fb_x` out 8: framebuffer write X coordinate.
- `fb_y` out 8: framebuffer write Y coordinate.
- `fb_color` out 12: framebuffer write colour.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of each sequence.
- `err` out 1: sticky watchdog flag.
- `cur_eng` out 2: index of the selected engine.

## Operation
- States: IDLE, CLEAR (only with the macro), SELECT, ARM, RUN, DONE.
- IDLE:
  - `start`=1 captures `mask_q`, clears `err` and goes to CLEAR or SELECT.
  - `start` is ignored in every other state.
- SELECT:
  - If `mask_q`==0, go to DONE.
  - Otherwise `cur_eng` takes the lowest set bit of `mask_q`; go to ARM.
- ARM (1 cycle): `eng_rst[cur_eng]`=1; go to RUN.
- RUN:
  - `eng_enable[cur_eng]`=1 and the watchdog counter increments each cycle.
  - If `eng_finished[cur_eng]`=1: clear `mask_q[cur_eng]` and go to SELECT.
  - Else if the counter has reached TIMEOUT: set `err`, clear `mask_q[cur_eng]` and go to SELECT.
  - Finished and timeout in the same cycle count as finished; `err` is not set.
- DONE (1 cycle): `done`=1; go to IDLE.
- `eng_rst`, `eng_enable`, `busy` and `done` are Moore-decoded from the registered state.
- Pixel path:
  - In RUN, with `eng_finished[cur_eng]`=0, the selected engine's x/y/colour are registered onto `fb_*` and `fb_we`=1 on the next cycle.
  - `fb_we` is 0 in all other cases; `fb_*` hold their previous values.
- Watchdog counter is 16-bit and is zeroed on entry to ARM.

## Timing
- Reset values: every output is 0; state is IDLE; `mask_q`=0.
- `start` accepted at edge t: `busy`=1 from t+1.
- Per engine: one SELECT cycle plus one ARM cycle precede RUN.
- `fb_*` latency is 1 cycle from the engine outputs.
- An engine finishing at RUN cycle n yields exactly n−1 writes if it raised `finished` on RUN cycle n.
- An empty mask without clear: SELECT then DONE; `done` is high 2 cycles after acceptance.
- `reset` asserted mid-sequence: everything returns to reset values asynchronously. No `done` pulse is produced; `err` is cleared.

## Configuration
- `VGA_SCHED_CLEAR_EN` defined:
  - After accepting `start`, enter CLEAR before the first SELECT.
  - CLEAR scans y 0..YMAX (outer) and x 0..XMAX (inner), one pixel per cycle, with `fb_we`=1 and `fb_color`=BG_COLOR.
  - That is (XMAX+1)*(YMAX+1) writes, registered with 1-cycle latency.
  - After the write of (XMAX,YMAX), go to SELECT.
- Macro undefined: the CLEAR state and its counters are not compiled; IDLE goes directly to SELECT.

## Test plan
- Reset: `reset`=0 in the middle of RUN → all outputs 0 immediately. After release, `start` with mask 2'b01 runs normally.
- N_ENG=2, mask 2'b11, engine models raise `finished` at RUN cycles 6 and 4:
  - Engine 0 sequence is `eng_rst[0]` pulse, 5 writes, then engine 1 sequence is `eng_rst[1]` pulse, 3 writes.
  - Exactly one `done` pulse; `err`=0.
- Mask 2'b10 → `eng_enable[0]` and `eng_rst[0]` never assert; `cur_eng`=1. Mask 2'b00 → `done` 2 cycles after `start`, zero writes.
- TIMEOUT=16, engine 0 never finishes, mask 2'b11:
  - `eng_enable[0]` drops after 16 RUN cycles and `err`=1.
  - Engine 1 still runs and `done` pulses.
  - The next accepted `start` clears `err`.
- `start` held high for the whole sequence → exactly one sequence runs. A second sequence begins only if `start` is still high in IDLE after DONE.
- With `VGA_SCHED_CLEAR_EN`, XMAX=3, YMAX=1, BG_COLOR=12'hABC → 8 writes (0,0),(1,0)..(3,1) of 12'hABC before `eng_rst[0]` asserts.
